joypad_port: RTL

JOYPAD_PORT -- requirements
Module: joypad_port

---
 rtl/joypad_port.sv | 133 +++++++++++++
 1 files changed

// File: rtl/joypad_port.sv
`default_nettype none
// ============================================================================
// Module      : joypad_port
// Description : Two-port serial game-controller interface at $4016/$4017.
//               A write to $4016 sets the latch/strobe bit. While strobe is
//               high, both shift registers track the live button vectors.
//               Once strobe is low, each decoded read of a port returns one
//               button bit (A first) and shifts that port by one position.
//               After eight reads the port returns 1.
// Ports       : clk          - system clock, state changes on posedge
//               reset        - asynchronous, active-high reset
//               cpu_ce       - one-clk qualifier for the active bus phase
//               cpu_addr     - CPU address bus
//               cpu_rd       - CPU read access (valid with cpu_ce)
//               cpu_wr       - CPU write access (valid with cpu_ce)
//               cpu_din      - CPU write data
//               pad1_buttons - port 1 buttons {A,B,Sel,Start,U,D,L,R}, 1=pressed
//               pad2_buttons - port 2 buttons, same encoding
//               cpu_dout     - read data: {OPEN_BUS, 4'b0000, serial bit}
//               dout_en      - high while cpu_dout drives a decoded read
//               strobe       - current latch/strobe bit
// Revision    : 1.0 - initial release
// ============================================================================
module joypad_port #(
    parameter logic [2:0] OPEN_BUS = 3'b010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_din,
    input  logic [7:0]  pad1_buttons,
    input  logic [7:0]  pad2_buttons,
    output logic [7:0]  cpu_dout,
    output logic        dout_en,
    output logic        strobe
);

    localparam logic [15:0] c_ADDR_PORT1 = 16'h4016;
    localparam logic [15:0] c_ADDR_PORT2 = 16'h4017;
    localparam logic [3:0]  c_CNT_MAX    = 4'd8;

    logic       r_strobe;
    logic [7:0] r_sr1;
    logic [7:0] r_sr2;
    logic [3:0] r_cnt1;
    logic [3:0] r_cnt2;

    logic w_sel1;
    logic w_sel2;
    logic w_rd1;
    logic w_rd2;
    logic w_wr1;
    logic w_bit1;
    logic w_bit2;

    // Only bit 0 of the write data is meaningful to this port.
    logic w_unused_din;
    assign w_unused_din = ^cpu_din[7:1];

    assign w_sel1 = (cpu_addr == c_ADDR_PORT1);
    assign w_sel2 = (cpu_addr == c_ADDR_PORT2);

    // All accesses are qualified by cpu_ce so a read stretched over several
    // clocks shifts exactly once.
    assign w_rd1 = cpu_ce & cpu_rd & w_sel1;
    assign w_rd2 = cpu_ce & cpu_rd & w_sel2;
    assign w_wr1 = cpu_ce & cpu_wr & w_sel1;

    // While strobed the controller reports live A. After eight shifts the
    // register is exhausted and the line idles high.
    always_comb begin
        w_bit1 = r_sr1[7];
        w_bit2 = r_sr2[7];
        if (r_strobe) begin
            w_bit1 = pad1_buttons[7];
            w_bit2 = pad2_buttons[7];
        end else begin
            if (r_cnt1 >= c_CNT_MAX) w_bit1 = 1'b1;
            if (r_cnt2 >= c_CNT_MAX) w_bit2 = 1'b1;
        end
    end

    always_comb begin
        cpu_dout = 8'h00;
        dout_en  = 1'b0;
        if (w_rd1) begin
            cpu_dout = {OPEN_BUS, 4'b0000, w_bit1};
            dout_en  = 1'b1;
        end else if (w_rd2) begin
            cpu_dout = {OPEN_BUS, 4'b0000, w_bit2};
            dout_en  = 1'b1;
        end
    end

    assign strobe = r_strobe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_strobe <= 1'b0;
            r_sr1    <= 8'h00;
            r_sr2    <= 8'h00;
            r_cnt1   <= 4'd0;
            r_cnt2   <= 4'd0;
        end else begin
            if (w_wr1) begin
                r_strobe <= cpu_din[0];
            end

            // Reload uses the current strobe value, so the edge that clears
            // strobe still captures the buttons one last time.
            if (r_strobe) begin
                r_sr1  <= pad1_buttons;
                r_sr2  <= pad2_buttons;
                r_cnt1 <= 4'd0;
                r_cnt2 <= 4'd0;
            end else begin
                if (w_rd1) begin
                    r_sr1 <= {r_sr1[6:0], 1'b1};
                    if (r_cnt1 < c_CNT_MAX) r_cnt1 <= r_cnt1 + 4'd1;
                end
                if (w_rd2) begin
                    r_sr2 <= {r_sr2[6:0], 1'b1};
                    if (r_cnt2 < c_CNT_MAX) r_cnt2 <= r_cnt2 + 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
